// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared definitions for the Game-of-Life frame engine:
//   - default grid geometry (cells per row/column, pixels per cell side)
//   - pixel colours for live and dead cells
//   - control FSM state encoding used by life_datapath
// Optional build macro used elsewhere in this slice: LIFE_TORUS_EN
// (toroidal edge wrap in life_next_gen).
// ---------------------------------------------------------------------------
package life_pkg;

    localparam int GRID_W_DEF  = 16;
    localparam int GRID_H_DEF  = 16;
    localparam int CELL_PX_DEF = 4;

    localparam logic [2:0] ALIVE_COLOUR = 3'b111;
    localparam logic [2:0] DEAD_COLOUR  = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } life_state_e;

    function automatic logic [2:0] cell_colour(input logic alive);
        return alive ? ALIVE_COLOUR : DEAD_COLOUR;
    endfunction

endpackage

// File: rtl/life_next_gen.sv
// ---------------------------------------------------------------------------
// life_next_gen
// Purely combinational Game-of-Life rule evaluation over the whole grid.
// Cell (x, y) lives at flat index y*GRID_W + x.
//   grid_i : current generation, flattened
//   next_o : next generation, flattened
// Rule: birth on exactly 3 live neighbours, survival on 2 or 3, else dead.
// Build macro LIFE_TORUS_EN: when defined the grid edges wrap (column
// GRID_W-1 touches column 0, row GRID_H-1 touches row 0); when undefined
// any neighbour position outside the grid counts as dead.
// ---------------------------------------------------------------------------
module life_next_gen
    import life_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic [GRID_W*GRID_H-1:0] grid_i,
    output logic [GRID_W*GRID_H-1:0] next_o
);

    localparam int IW = $clog2(GRID_W * GRID_H);

    logic [3:0] cnt;
    int         nx;
    int         ny;

    always_comb begin
        next_o = '0;
        cnt    = '0;
        nx     = 0;
        ny     = 0;
        for (int yy = 0; yy < GRID_H; yy++) begin
            for (int xx = 0; xx < GRID_W; xx++) begin
                cnt = '0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            nx = xx + dx;
                            ny = yy + dy;
`ifdef LIFE_TORUS_EN
                            // Adding the dimension first keeps the modulo
                            // operand non-negative for the -1 offsets.
                            nx  = (nx + GRID_W) % GRID_W;
                            ny  = (ny + GRID_H) % GRID_H;
                            cnt = cnt + {3'b000, grid_i[IW'(ny * GRID_W + nx)]};
`else
                            if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H) begin
                                cnt = cnt + {3'b000, grid_i[IW'(ny * GRID_W + nx)]};
                            end
`endif
                        end
                    end
                end
                next_o[IW'(yy * GRID_W + xx)] = (cnt == 4'd3) ||
                    ((cnt == 4'd2) && grid_i[IW'(yy * GRID_W + xx)]);
            end
        end
    end

endmodule

// File: rtl/life_datapath.sv
// ---------------------------------------------------------------------------
// life_datapath
// Game-of-Life grid store, switch-driven cell editor and frame engine.
// In IDLE the user latches an X coordinate (ldX) and toggles the cell at
// (x_reg, data_in) on each rising edge of ldY. A draw request scans every
// cell out as a CELL_PX x CELL_PX block, one pixel per clock, then advances
// the grid one generation and pulses stop for one cycle.
//
// Ports:
//   clock    in   system clock, all logic on posedge
//   reset    in   synchronous active-high reset
//   ldX      in   latch X cell coordinate from data_in
//   ldY      in   Y-load key (level); its rising edge toggles a cell
//   draw     in   start frame rendering
//   data_in  in   [7:0] switch value, low coordinate bits used
//   x        out  [7:0] pixel x to VGA adapter
//   y        out  [6:0] pixel y to VGA adapter
//   colour   out  [2:0] pixel colour (111 alive, 000 dead)
//   plot     out  VGA write enable
//   stop     out  one-cycle pulse when frame and generation step finish
//   state_o  out  [1:0] current FSM state (debug visibility)
//
// Handshake: draw is a level request sampled only in IDLE; once sampled the
// frame always runs to completion and ends with exactly one stop cycle, after
// which a still-high draw starts the next frame.
//
// Build macro LIFE_TORUS_EN selects toroidal edges inside life_next_gen.
// ---------------------------------------------------------------------------
module life_datapath
    import life_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int CELL_PX = CELL_PX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ldX,
    input  logic       ldY,
    input  logic       draw,
    input  logic [7:0] data_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       stop,
    output logic [1:0] state_o
);

    localparam int LW = $clog2(GRID_W);
    localparam int LH = $clog2(GRID_H);
    localparam int LP = $clog2(CELL_PX);
    localparam int NC = GRID_W * GRID_H;
    // Scan counter layout {cy, cx, py, px}: px innermost, cell y outermost.
    // Its top LH+LW bits are therefore the flat cell index directly.
    localparam int SW = LH + LW + 2 * LP;

    life_state_e    state_q;
    logic [LW-1:0]  x_reg_q;
    logic           ldy_prev_q;
    logic [NC-1:0]  grid_q;
    logic [SW-1:0]  scan_q;
    logic [7:0]     x_q;
    logic [6:0]     y_q;
    logic [2:0]     colour_q;
    logic           plot_q;
    logic           stop_q;

    logic [NC-1:0]  grid_next_d;
    logic [NC-1:0]  grid_toggle_d;
    logic [SW-1:0]  scan_d;
    logic           ldy_rise;
    logic           unused_data;

    // Only the low coordinate bits of the switches are meaningful.
    assign unused_data = &{1'b0, data_in};

    function automatic logic [7:0] pix_x(input logic [SW-1:0] s);
        logic [SW-1:0] px;
        logic [SW-1:0] cx;
        px = s & SW'(CELL_PX - 1);
        cx = (s >> (2 * LP)) & SW'(GRID_W - 1);
        return 8'((cx << LP) | px);
    endfunction

    function automatic logic [6:0] pix_y(input logic [SW-1:0] s);
        logic [SW-1:0] py;
        logic [SW-1:0] cy;
        py = (s >> LP) & SW'(CELL_PX - 1);
        cy = s >> (2 * LP + LW);
        return 7'((cy << LP) | py);
    endfunction

    life_next_gen #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_gen (
        .grid_i (grid_q),
        .next_o (grid_next_d)
    );

    assign scan_d   = scan_q + 1'b1;
    assign ldy_rise = ldY & ~ldy_prev_q;

    // The toggle uses the registered x_reg, so an ldX in the same cycle
    // only affects later toggles.
    always_comb begin
        grid_toggle_d = grid_q;
        grid_toggle_d[{data_in[LH-1:0], x_reg_q}] = ~grid_q[{data_in[LH-1:0], x_reg_q}];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            x_reg_q    <= '0;
            ldy_prev_q <= 1'b0;
            grid_q     <= '0;
            scan_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= DEAD_COLOUR;
            plot_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            // Tracked in every state so a key held through a frame
            // never registers as a fresh edge afterwards.
            ldy_prev_q <= ldY;
            stop_q     <= 1'b0;
            plot_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (draw) begin
                        // Pixel 0 is emitted on this same edge so the first
                        // plot is visible the cycle after draw is sampled.
                        state_q  <= SCAN;
                        scan_q   <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        colour_q <= cell_colour(grid_q[0]);
                        plot_q   <= 1'b1;
                    end else begin
                        if (ldX) begin
                            x_reg_q <= data_in[LW-1:0];
                        end
                        if (ldy_rise) begin
                            grid_q <= grid_toggle_d;
                        end
                    end
                end
                SCAN: begin
                    if (scan_q == {SW{1'b1}}) begin
                        state_q <= STEP;
                    end else begin
                        scan_q   <= scan_d;
                        x_q      <= pix_x(scan_d);
                        y_q      <= pix_y(scan_d);
                        colour_q <= cell_colour(grid_q[scan_d[SW-1:2*LP]]);
                        plot_q   <= 1'b1;
                    end
                end
                STEP: begin
                    grid_q  <= grid_next_d;
                    stop_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign stop    = stop_q;
    assign state_o = state_q;

endmodule

// File: doc/life_datapath.md
Name: life_datapath

Overview:
- Datapath and frame engine under the draw/load control FSM. It consumes ldX, ldY and draw, and returns the stop pulse that ends the FSM's DRAW state.
- Holds a GRID_W x GRID_H Game-of-Life cell grid and lets the user toggle cells via switch-entered coordinates.
- On draw, scans the grid out to the VGA adapter as CELL_PX x CELL_PX pixel blocks, then advances one generation.

Parameters:
GRID_W, 16, cells per row (power of 2, <=32)
GRID_H, 16, cells per column (power of 2, <=32)
CELL_PX, 4, pixel side length of one cell (power of 2); GRID_W*CELL_PX<=256, GRID_H*CELL_PX<=128

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
ldX  in  1  latch X cell coordinate from data_in
ldY  in  1  Y-load strobe (level, held while key held)
draw  in  1  start/continue frame rendering
data_in  in  8  switch value; low log2(GRID_W)/log2(GRID_H) bits used
x  out  8  pixel x to VGA adapter
y  out  7  pixel y to VGA adapter
colour  out  3  pixel colour (3'b111 alive, 3'b000 dead)
plot  out  1  write-enable to VGA adapter
stop  out  1  one-cycle pulse: frame + generation step complete

Behaviour:
- Reset (sync, high), from any state, mid-scan included: state IDLE, grid all dead, x_reg/y_reg=0, x=0, y=0, colour=0, plot=0, stop=0, ldY_prev=0.
- FSM states: IDLE, SCAN, STEP, DONE.
- IDLE:
  - ldX=1: x_reg <= data_in[log2(GRID_W)-1:0] every cycle.
  - ldY rising edge (ldY & !ldY_prev): toggle cell (x_reg, data_in[log2(GRID_H)-1:0]). Holding ldY toggles exactly once.
  - ldX and ldY together: use the old x_reg for the toggle.
  - draw=1: go to SCAN, counters cleared.
- SCAN:
  - One pixel per cycle, row-major: px innermost, then py, then cell x, then cell y.
  - Registered outputs: x = cx*CELL_PX+px, y = cy*CELL_PX+py, colour from cell, plot=1.
  - First plot valid the cycle after draw is sampled; exactly GRID_W*GRID_H*CELL_PX^2 plot cycles (4096 default).
  - Ignores draw deassertion and loads until complete.
  - After the last pixel, go to STEP with plot=0.
- STEP: one cycle. Whole grid <= next generation: birth on exactly 3 live neighbours, survive on 2 or 3, else dead. Then go to DONE.
- DONE: stop=1 for one cycle, then IDLE. Control drops draw in the following cycle; if draw is still high in IDLE, a new frame starts.
- Frame latency from draw: N_pixels + 2 cycles to the stop pulse.
- ldY_prev updates every cycle in all states, so a held key never causes a late toggle.
- Neighbour counts are 4-bit; edges are handled per the optional feature.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: grid edges wrap (toroidal); column GRID_W-1 neighbours column 0, row GRID_H-1 neighbours row 0.
- Undefined: cells outside the grid count as dead; no wrap.

Decomposition:
- Package life_pkg:
  - colour constants ALIVE_COLOUR=3'b111, DEAD_COLOUR=3'b000
  - FSM state localparams IDLE/SCAN/STEP/DONE
  - default GRID_W/GRID_H/CELL_PX
- Sub-module life_next_gen: combinational. Input is the flattened current grid; output is the flattened next grid. It contains the neighbour counting and the LIFE_TORUS_EN edge logic.
- life_datapath keeps the grid register, load logic, scan counters and FSM.

Test Plan:
- Reset then draw=1 -> 4096 consecutive plot=1 cycles, all colour=000, x 0..63, y 0..63 in scan order; stop=1 exactly at cycle 4098 after draw, for one cycle.
- data_in=3, ldX pulse; data_in=5, ldY pulse; draw -> pixels x 12..15, y 20..23 colour=111, all others 000.
- ldY held 10 cycles with x_reg=3, data_in=5 -> cell (3,5) alive. Second ldY pulse -> dead, so the next frame is all 000.
- Vertical blinker (5,4),(5,5),(5,6); one frame -> grid holds (4,5),(5,5),(6,5). Second frame plots the horizontal pattern (x 16..27, y 20..23 white).
- Cells (15,0),(0,0),(1,0), one frame:
  - LIFE_TORUS_EN defined -> next grid (0,15),(0,0),(0,1).
  - Undefined -> next grid empty.
- Reset asserted after 100 plots -> plot=0 the next cycle, no stop pulse, the following frame is all 000.
